// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------+
// | arb_pkg : shared types and constants for the FU issue arbiter         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

    // Busy countdown width covers BUSY_CYCLES up to 255.
    localparam int c_cnt_w = $clog2(255 + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/priority_encoder.sv
// +----------------------------------------------------------------------+
// | priority_encoder : MSB-first priority encoder with valid flag         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_encoder #(
    parameter int W = 8
) (
    input  logic [W-1:0]         req_i,
    output logic [$clog2(W)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(W);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = 0; i < W; i++) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fu_issue_arbiter.sv
// +----------------------------------------------------------------------+
// | fu_issue_arbiter : round-robin RS-to-FU issue arbiter with busy gap   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module fu_issue_arbiter
    import arb_pkg::*;
#(
    parameter int N           = 8,
    parameter int BUSY_CYCLES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 flush_i,
    input  logic                 fu_ready_i,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic [N-1:0]         grant_oh_o,
    output logic                 fire_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(N);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx_nxt;
    logic [IW-1:0]       r_last;
    logic [IW-1:0]       w_last_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;

    logic [N-1:0]        w_eff;
    logic [N-1:0]        w_mask;
    logic [N-1:0]        w_masked;
    logic                w_sel_en;
    logic [IW-1:0]       w_lo_idx;
    logic                w_lo_valid;
    logic [IW-1:0]       w_all_idx;
    logic                w_all_valid;
    logic [IW-1:0]       w_winner;

    priority_encoder #(.W(N)) u_pe_masked (
        .req_i   (w_masked),
        .idx_o   (w_lo_idx),
        .valid_o (w_lo_valid)
    );

    priority_encoder #(.W(N)) u_pe_all (
        .req_i   (w_eff),
        .idx_o   (w_all_idx),
        .valid_o (w_all_valid)
    );

    assign w_winner = w_lo_valid ? w_lo_idx : w_all_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // The entry firing now still has req_i high; keep it out of the pick.
        w_eff = req_i & ~(fire_o ? grant_oh_o : '0);
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i < int'(r_last));
        end
        w_masked = w_eff & w_mask;

        w_sel_en = (r_state == ST_IDLE)
                 || ((r_state == ST_OFFER) && fire_o && (BUSY_CYCLES == 0))
                 || ((r_state == ST_BUSY) && (r_cnt == c_cnt_w'(1)));

        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;

        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            if (fire_o) begin
                w_last_nxt = r_idx;
            end
            if (w_sel_en) begin
                w_cnt_nxt = '0;
                if (w_all_valid) begin
                    w_state_nxt = ST_OFFER;
                    w_idx_nxt   = w_winner;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end else if ((r_state == ST_OFFER) && fire_o) begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = c_cnt_w'(BUSY_CYCLES);
            end else if (r_state == ST_BUSY) begin
                w_cnt_nxt = r_cnt - c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        grant_valid_o = (r_state == ST_OFFER);
        busy_o        = (r_state == ST_BUSY);
        grant_idx_o   = r_idx;
        fire_o        = grant_valid_o && fu_ready_i && !flush_i;
        grant_oh_o    = '0;
        if (grant_valid_o) begin
            grant_oh_o[r_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fu_issue_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fu_issue_arbiter : checks a pipelined (B=0) and a B=3 arbiter      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fu_issue_arbiter;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req = '0;
    logic flush = 1'b0;
    logic ready = 1'b0;

    logic [1:0]        gv, fire_v, busy_v;
    logic [1:0][2:0]   gi;
    logic [1:0][N-1:0] goh;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fu_issue_arbiter #(.N(N), .BUSY_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .flush_i(flush), .fu_ready_i(ready),
        .grant_valid_o(gv[0]), .grant_idx_o(gi[0]), .grant_oh_o(goh[0]),
        .fire_o(fire_v[0]), .busy_o(busy_v[0])
    );

    fu_issue_arbiter #(.N(N), .BUSY_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .flush_i(flush), .fu_ready_i(ready),
        .grant_valid_o(gv[1]), .grant_idx_o(gi[1]), .grant_oh_o(goh[1]),
        .fire_o(fire_v[1]), .busy_o(busy_v[1])
    );

    // Reference model: offer flag, offered index, last winner, busy cycles left.
    logic m_valid [2];
    int   m_idx   [2];
    int   m_last  [2];
    int   m_cnt   [2];
    logic         mf;
    logic [N-1:0] me;
    int           mw;

    // Next winner: scan downward from just below last winner, wrapping.
    function automatic int pick(input logic [N-1:0] e, input int last);
        for (int s = 1; s <= N; s++) begin
            if (e[(last - s + N) % N]) return (last - s + N) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] <= 1'b0; m_idx[k] <= 0; m_last[k] <= 0; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mf = m_valid[k] && ready && !flush;
                me = req & ~(mf ? (N'(1) << m_idx[k]) : '0);
                mw = pick(me, m_last[k]);
                if (flush) begin
                    m_valid[k] <= 1'b0;
                    m_cnt[k]   <= 0;
                end else if (m_valid[k]) begin
                    if (mf) begin
                        m_last[k] <= m_idx[k];
                        if (k == 0) begin
                            m_valid[k] <= (mw >= 0);
                            if (mw >= 0) m_idx[k] <= mw;
                        end else begin
                            m_valid[k] <= 1'b0;
                            m_cnt[k]   <= 3;
                        end
                    end
                end else if (m_cnt[k] > 1) begin
                    m_cnt[k] <= m_cnt[k] - 1;
                end else begin
                    m_cnt[k]   <= 0;
                    m_valid[k] <= (mw >= 0);
                    if (mw >= 0) m_idx[k] <= mw;
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic f, input logic rd);
        @(negedge clk);
        req = r; flush = f; ready = rd;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(8'hFF, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if ({gv[k], gi[k], goh[k], fire_v[k], busy_v[k]} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_outputs dut%0d: got v=%b i=%0d oh=%h f=%b b=%b want all 0",
                             k, gv[k], gi[k], goh[k], fire_v[k], busy_v[k]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; req = '0; ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(8'h00, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (gv[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_after_reset dut%0d: got v=%b b=%b want 0 0", k, gv[k], busy_v[k]);
                end
            end
        end
    endtask

    task automatic test_rotation();
        int exp_seq [5] = '{5, 2, 0, 5, 2};
        drive(8'h25, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(8'h25, 1'b0, 1'b1);
            vectors++;
            if (gv[0] !== 1'b1 || fire_v[0] !== 1'b1 || gi[0] !== 3'(exp_seq[c])) begin
                miscompares++;
                $display("FAIL rotation[%0d]: got v=%b f=%b idx=%0d want 1 1 %0d",
                         c, gv[0], fire_v[0], gi[0], exp_seq[c]);
            end
        end
        drive(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        drive(8'h80, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive((c < 3) ? 8'h80 : 8'h81, 1'b0, 1'b0);
            vectors++;
            if (gv[0] !== 1'b1 || gi[0] !== 3'd7 || fire_v[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: got v=%b idx=%0d f=%b want 1 7 0", c, gv[0], gi[0], fire_v[0]);
            end
        end
        drive(8'h81, 1'b0, 1'b1);
        vectors++;
        if (fire_v[0] !== 1'b1 || gi[0] !== 3'd7 || goh[0] !== 8'h80) begin
            miscompares++;
            $display("FAIL hold_fire: got f=%b idx=%0d oh=%h want 1 7 80", fire_v[0], gi[0], goh[0]);
        end
        drive(8'h01, 1'b0, 1'b1);
        vectors++;
        if (gv[0] !== 1'b1 || gi[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL hold_single_fire: got v=%b idx=%0d want 1 0", gv[0], gi[0]);
        end
        drive(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        int exp_seq [3] = '{7, 0, 7};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(8'h81, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(8'h81, 1'b0, 1'b1);
            vectors++;
            if (gv[0] !== 1'b1 || gi[0] !== 3'(exp_seq[c])) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got v=%b idx=%0d want 1 %0d", c, gv[0], gi[0], exp_seq[c]);
            end
        end
        drive(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive(8'h08, 1'b0, 1'b0);
        drive(8'h08, 1'b1, 1'b1);
        vectors++;
        if (gv[0] !== 1'b1 || gi[0] !== 3'd3 || fire_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wins: got v=%b idx=%0d f=%b want 1 3 0", gv[0], gi[0], fire_v[0]);
        end
        drive(8'h08, 1'b0, 1'b0);
        vectors++;
        if (gv[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got v=%b want 0", gv[0]);
        end
        drive(8'h08, 1'b0, 1'b0);
        vectors++;
        if (gv[0] !== 1'b1 || gi[0] !== 3'd3) begin
            miscompares++;
            $display("FAIL flush_reoffer: got v=%b idx=%0d want 1 3", gv[0], gi[0]);
        end
        drive(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_busy();
        logic [2:0]   id;
        logic [N-1:0] r;
        drive(8'h03, 1'b0, 1'b0);
        drive(8'h03, 1'b0, 1'b1);
        vectors++;
        if (gv[1] !== 1'b1 || fire_v[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_first_fire: got v=%b f=%b want 1 1", gv[1], fire_v[1]);
        end
        id = gi[1];
        r  = 8'h03 & ~(8'h01 << id);
        for (int c = 1; c <= 3; c++) begin
            drive(r, 1'b0, 1'b1);
            vectors++;
            if (busy_v[1] !== 1'b1 || gv[1] !== 1'b0 || fire_v[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_window t+%0d: got b=%b v=%b f=%b want 1 0 0", c, busy_v[1], gv[1], fire_v[1]);
            end
        end
        drive(r, 1'b0, 1'b1);
        vectors++;
        if (gv[1] !== 1'b1 || busy_v[1] !== 1'b0 || gi[1] !== ((id == 3'd0) ? 3'd1 : 3'd0)) begin
            miscompares++;
            $display("FAIL busy_next_grant: got v=%b b=%b idx=%0d want 1 0 %0d",
                     gv[1], busy_v[1], gi[1], (id == 3'd0) ? 1 : 0);
        end
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h10, 1'b1, 1'b0);
        vectors++;
        if (busy_v[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_at_flush: got b=%b want 1", busy_v[1]);
        end
        drive(8'h10, 1'b0, 1'b0);
        vectors++;
        if (busy_v[1] !== 1'b0 || gv[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_flushed: got b=%b v=%b want 0 0", busy_v[1], gv[1]);
        end
        drive(8'h10, 1'b0, 1'b0);
        vectors++;
        if (gv[1] !== 1'b1 || gi[1] !== 3'd4) begin
            miscompares++;
            $display("FAIL busy_flush_regrant: got v=%b idx=%0d want 1 4", gv[1], gi[1]);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({gv[1], gi[1], goh[1], busy_v[1], fire_v[1]} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b idx=%0d oh=%h b=%b f=%b want all 0",
                     gv[1], gi[1], goh[1], busy_v[1], fire_v[1]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] r = '0;
        logic         ef;
        logic [N-1:0] eoh;
        for (int c = 0; c < 400; c++) begin
            r = (r | N'($urandom & $urandom)) & ~N'($urandom & $urandom);
            drive(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            for (int k = 0; k < 2; k++) begin
                ef  = m_valid[k] && ready && !flush;
                eoh = m_valid[k] ? (N'(1) << m_idx[k]) : '0;
                vectors++;
                if (gv[k] !== m_valid[k] || busy_v[k] !== (m_cnt[k] != 0) || fire_v[k] !== ef
                    || goh[k] !== eoh || (m_valid[k] && gi[k] !== 3'(m_idx[k]))) begin
                    miscompares++;
                    $display("FAIL random[%0d] dut%0d: got v=%b i=%0d oh=%h f=%b b=%b want v=%b i=%0d oh=%h f=%b b=%b",
                             c, k, gv[k], gi[k], goh[k], fire_v[k], busy_v[k],
                             m_valid[k], m_idx[k], eoh, ef, (m_cnt[k] != 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_flush();
        test_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
